// File: rtl/mac_vlg_pkg.sv
// rtl/mac_vlg_pkg.sv - shared types, constants and CRC helper for the MAC transmitter
package mac_vlg_pkg;

    localparam logic [7:0]  SFD           = 8'hD5;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        PAD,
        FCS,
        IFG
    } tx_state_e;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
    } tx_meta_t;

    // LSB-first CRC-32 step over one byte using the bit-reversed polynomial
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dat);
        logic [31:0] poly_r;
        logic [31:0] c;
        for (int i = 0; i < 32; i++) begin
            poly_r[i] = CRC32_POLY[31-i];
        end
        c = crc ^ {24'h0, dat};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_vlg_crc32.sv
// rtl/mac_vlg_crc32.sv - byte-wide reflected CRC-32 accumulator, one byte per cycle
module mac_vlg_crc32
    import mac_vlg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        val,
    input  logic [7:0]  dat,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC32_INIT;
        end else if (val) begin
            crc_d = crc32_byte(crc_q, dat);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mac_vlg_tx.sv
// rtl/mac_vlg_tx.sv - Ethernet MAC transmitter: preamble, header, payload, pad, FCS, IFG
module mac_vlg_tx
    import mac_vlg_pkg::*;
#(
    parameter int IFG_LEN      = 12,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MTU          = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mac_rdy,
    input  logic        mac_strm_val,
    input  logic [7:0]  mac_strm_dat,
    input  logic        mac_strm_sof,
    input  logic        mac_strm_eof,
    input  tx_meta_t    mac_meta,
    output logic        mac_req,
    output logic        mac_ack,
    output logic        mac_done,
    output logic [7:0]  phy_dat,
    output logic        phy_val,
    output logic        phy_err
);

    localparam logic [3:0] HDR_LAST = 4'd13;
    localparam logic [3:0] IFG_LAST = 4'(IFG_LEN - 1);

    tx_state_e    state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [10:0]  pay_cnt_q, pay_cnt_d;
    logic [3:0]   ifg_cnt_q, ifg_cnt_d;
    logic [111:0] hdr_q, hdr_d;
    logic         crc_clr, crc_val;
    logic [31:0]  crc;
    logic [31:0]  fcs;
    logic         unused_sof;

    // Frame start is known from the req handshake, so sof carries no extra information
    assign unused_sof = mac_strm_sof;
    assign fcs        = ~crc;

    mac_vlg_crc32 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .val   (crc_val),
        .dat   (phy_dat),
        .crc   (crc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pay_cnt_d = pay_cnt_q;
        ifg_cnt_d = (ifg_cnt_q != IFG_LAST) ? ifg_cnt_q + 4'd1 : ifg_cnt_q;
        hdr_d     = hdr_q;
        phy_dat   = 8'h00;
        phy_val   = 1'b0;
        phy_err   = 1'b0;
        mac_req   = 1'b0;
        mac_ack   = 1'b0;
        mac_done  = 1'b0;
        crc_clr   = 1'b0;
        crc_val   = 1'b0;

        case (state_q)
            IDLE: begin
                if (mac_rdy && ifg_cnt_q == IFG_LAST) begin
                    state_d = PREAMBLE;
                    cnt_d   = 4'd0;
                    hdr_d   = mac_meta;
                end
            end
            PREAMBLE: begin
                phy_val = 1'b1;
                crc_clr = 1'b1;
                mac_ack = (cnt_q == 4'd0);
                if (cnt_q == 4'(PREAMBLE_LEN)) begin
                    phy_dat = SFD;
                    state_d = HEADER;
                    cnt_d   = 4'd0;
                end else begin
                    phy_dat = PREAMBLE_BYTE;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            HEADER: begin
                phy_val = 1'b1;
                phy_dat = hdr_q[111:104];
                crc_val = 1'b1;
                hdr_d   = hdr_q << 8;
                if (cnt_q == HDR_LAST) begin
                    mac_req   = 1'b1;
                    state_d   = PAYLOAD;
                    pay_cnt_d = 11'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PAYLOAD: begin
                phy_val = 1'b1;
                phy_dat = mac_strm_dat;
                // Underflow or a byte beyond MTU: mark the cycle as an error and skip the FCS
                if (!mac_strm_val || pay_cnt_q == 11'(MTU)) begin
                    phy_err   = 1'b1;
                    state_d   = IFG;
                    ifg_cnt_d = 4'd0;
                end else begin
                    crc_val   = 1'b1;
                    pay_cnt_d = pay_cnt_q + 11'd1;
                    if (mac_strm_eof) begin
                        state_d = (pay_cnt_q < 11'(MIN_PAYLOAD - 1)) ? PAD : FCS;
                        cnt_d   = 4'd0;
                    end else begin
                        mac_req = 1'b1;
                    end
                end
            end
            PAD: begin
                phy_val   = 1'b1;
                crc_val   = 1'b1;
                pay_cnt_d = pay_cnt_q + 11'd1;
                if (pay_cnt_q == 11'(MIN_PAYLOAD - 1)) begin
                    state_d = FCS;
                    cnt_d   = 4'd0;
                end
            end
            FCS: begin
                phy_val = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    phy_dat = fcs[7:0];
                    2'd1:    phy_dat = fcs[15:8];
                    2'd2:    phy_dat = fcs[23:16];
                    default: phy_dat = fcs[31:24];
                endcase
                if (cnt_q == 4'd3) begin
                    mac_done  = 1'b1;
                    state_d   = IFG;
                    ifg_cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            IFG: begin
                // The IDLE cycle that follows supplies the last idle cycle of the gap
                if (ifg_cnt_q == 4'(IFG_LEN - 2)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            pay_cnt_q <= 11'd0;
            ifg_cnt_q <= IFG_LAST;
            hdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pay_cnt_q <= pay_cnt_d;
            ifg_cnt_q <= ifg_cnt_d;
            hdr_q     <= hdr_d;
        end
    end

endmodule

// File: tb/tb_mac_vlg_tx.sv
// tb/tb_mac_vlg_tx.sv - directed self-checking bench for mac_vlg_tx and its CRC helper
module tb_mac_vlg_tx;
    import mac_vlg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mac_rdy, mac_strm_val, mac_strm_sof, mac_strm_eof;
    logic [7:0]  mac_strm_dat;
    tx_meta_t    mac_meta;
    logic        mac_req, mac_ack, mac_done, phy_val, phy_err;
    logic [7:0]  phy_dat;
    logic        crc_clr, crc_val;
    logic [7:0]  crc_dat;
    logic [31:0] crc_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap[$];
    int flen[4];
    int gap[4];
    int n_end, n_gap, err_cyc, err_pos, done_cnt, done_pos, ack_cnt, first_val;

    always #5 clk = ~clk;

    mac_vlg_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mac_rdy      (mac_rdy),
        .mac_strm_val (mac_strm_val),
        .mac_strm_dat (mac_strm_dat),
        .mac_strm_sof (mac_strm_sof),
        .mac_strm_eof (mac_strm_eof),
        .mac_meta     (mac_meta),
        .mac_req      (mac_req),
        .mac_ack      (mac_ack),
        .mac_done     (mac_done),
        .phy_dat      (phy_dat),
        .phy_val      (phy_val),
        .phy_err      (phy_err)
    );

    mac_vlg_crc32 u_crc_solo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .val   (crc_val),
        .dat   (crc_dat),
        .crc   (crc_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [7:0] seed, input int i);
        return seed + 8'(i * 13);
    endfunction

    function automatic logic [31:0] ref_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic cmp_frame(input string tag, input int offset, input tx_meta_t meta,
                             input int len, input logic [7:0] seed);
        logic [7:0]   e[$];
        logic [111:0] h;
        logic [31:0]  c;
        int           mism;
        h    = meta;
        c    = 32'hFFFFFFFF;
        mism = 0;
        for (int k = 0; k < 7; k++) e.push_back(8'h55);
        e.push_back(8'hD5);
        for (int k = 0; k < 14; k++) e.push_back(h[111-8*k -: 8]);
        for (int i = 0; i < len; i++) e.push_back(pat(seed, i));
        for (int i = len; i < 46; i++) e.push_back(8'h00);
        for (int k = 8; k < e.size(); k++) c = ref_step(c, e[k]);
        c = ~c;
        for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
        for (int k = 0; k < e.size(); k++) begin
            if (offset + k >= cap.size()) mism++;
            else if (cap[offset+k] !== e[k]) mism++;
        end
        chk({tag, "_bytes"}, 32'(mism), 32'd0);
    endtask

    // Drives rdy and the payload source cycle by cycle while recording the PHY stream.
    task automatic run_frames(input string tag, input int nframes, input int len,
                              input logic [7:0] seed, input int drop_at, input int stop_at,
                              input int max_cyc);
        int frames_left, cyc, idx, idle, cur_len, frame_no;
        bit active, prev_val, stopped;
        frames_left = nframes;
        cyc = 0; idx = 0; idle = 0; cur_len = 0; frame_no = 0;
        active = 0; prev_val = 0; stopped = 0;
        cap.delete();
        n_end = 0; n_gap = 0; err_cyc = 0; err_pos = 0;
        done_cnt = 0; done_pos = 0; ack_cnt = 0; first_val = -1;
        @(posedge clk); #1;
        mac_rdy = 1'b1;
        while (cyc < max_cyc) begin
            @(negedge clk);
            if (phy_val) begin
                if (!prev_val && n_end > 0 && n_gap < 4) begin
                    gap[n_gap] = idle;
                    n_gap++;
                end
                if (first_val < 0) first_val = cyc;
                cap.push_back(phy_dat);
                cur_len++;
                if (phy_err) begin err_cyc++; err_pos = cur_len; end
                if (mac_done) begin done_cnt++; done_pos = cur_len; end
            end else if (prev_val) begin
                if (n_end < 4) flen[n_end] = cur_len;
                n_end++;
                cur_len = 0;
                idle = 1;
            end else begin
                idle++;
            end
            prev_val = phy_val;
            if (mac_ack) begin ack_cnt++; frames_left--; end

            if (active) begin
                if (idx == len - 1 || (frame_no == 0 && idx == drop_at)) begin
                    active = 0;
                    frame_no++;
                end else begin
                    idx++;
                end
            end else if (mac_req) begin
                active = 1;
                idx = 0;
            end

            @(posedge clk); #1;
            mac_rdy      = (frames_left > 0);
            mac_strm_val = active && !(frame_no == 0 && idx == drop_at);
            mac_strm_dat = active ? pat(seed, idx) : 8'h00;
            mac_strm_sof = active && idx == 0;
            mac_strm_eof = active && idx == len - 1;
            cyc++;
            if (stop_at >= 0 && active && idx == stop_at) begin
                stopped = 1;
                break;
            end
            if (n_end >= nframes && idle >= 14) break;
        end
        if (stop_at < 0) chk({tag, "_ended"}, 32'(n_end), 32'(nframes));
        else             chk({tag, "_stop"}, 32'(stopped), 32'd1);
        if (!stopped) begin
            mac_rdy = 0; mac_strm_val = 0; mac_strm_sof = 0; mac_strm_eof = 0; mac_strm_dat = 0;
        end
    endtask

    initial begin
        tx_meta_t m;
        string    s;

        rst_n = 1'b0;
        mac_rdy = 1'b1; mac_strm_val = 1'b1; mac_strm_dat = 8'hFF;
        mac_strm_sof = 1'b1; mac_strm_eof = 1'b1; mac_meta = '1;
        crc_clr = 0; crc_val = 0; crc_dat = 0;
        repeat (2) @(negedge clk);
        chk("rst_phy_val", 32'(phy_val), 32'd0);
        chk("rst_phy_dat", 32'(phy_dat), 32'd0);
        chk("rst_phy_err", 32'(phy_err), 32'd0);
        chk("rst_req", 32'(mac_req), 32'd0);
        chk("rst_ack", 32'(mac_ack), 32'd0);
        chk("rst_done", 32'(mac_done), 32'd0);
        mac_rdy = 0; mac_strm_val = 0; mac_strm_dat = 0; mac_strm_sof = 0; mac_strm_eof = 0;
        rst_n = 1'b1;

        // Standalone CRC on the check string
        s = "123456789";
        @(posedge clk); #1; crc_clr = 1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1; crc_clr = 0; crc_val = 1; crc_dat = s[i];
        end
        @(posedge clk); #1; crc_val = 0;
        @(negedge clk);
        chk("crc_check", ~crc_out, 32'hCBF43926);

        // 1-byte payload, broadcast destination
        m.dst_mac = 48'hFFFF_FFFF_FFFF; m.src_mac = 48'h0200_0000_0001; m.ethertype = 16'h0800;
        mac_meta = m;
        run_frames("t2", 1, 1, 8'hAB, -1, -1, 300);
        chk("t2_first_val", 32'(first_val), 32'd1);
        chk("t2_len", 32'(flen[0]), 32'd72);
        chk("t2_done_pos", 32'(done_pos), 32'd72);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        chk("t2_err", 32'(err_cyc), 32'd0);
        chk("t2_ack", 32'(ack_cnt), 32'd1);
        cmp_frame("t2", 0, m, 1, 8'hAB);

        // Two back-to-back 100-byte frames with rdy held high
        m.dst_mac = 48'h0011_2233_4455; m.src_mac = 48'h66AA_BBCC_DDEE; m.ethertype = 16'h86DD;
        mac_meta = m;
        run_frames("t3", 2, 100, 8'h11, -1, -1, 600);
        chk("t3_len0", 32'(flen[0]), 32'd126);
        chk("t3_len1", 32'(flen[1]), 32'd126);
        chk("t3_gap", 32'(gap[0]), 32'd12);
        chk("t3_ack", 32'(ack_cnt), 32'd2);
        chk("t3_done", 32'(done_cnt), 32'd2);
        cmp_frame("t3f0", 0, m, 100, 8'h11);
        cmp_frame("t3f1", 126, m, 100, 8'h11);

        // Underflow on payload byte 20, then a normal frame
        run_frames("t4", 2, 50, 8'h33, 19, -1, 600);
        chk("t4_len0", 32'(flen[0]), 32'd42);
        chk("t4_len1", 32'(flen[1]), 32'd76);
        chk("t4_err", 32'(err_cyc), 32'd1);
        chk("t4_err_pos", 32'(err_pos), 32'd42);
        chk("t4_done", 32'(done_cnt), 32'd1);
        chk("t4_gap", 32'(gap[0]), 32'd12);
        chk("t4_ack", 32'(ack_cnt), 32'd2);
        cmp_frame("t4f1", 42, m, 50, 8'h33);

        // One byte over MTU aborts; exactly MTU completes
        run_frames("t5a", 1, 1501, 8'h5A, -1, -1, 2000);
        chk("t5a_len", 32'(flen[0]), 32'd1523);
        chk("t5a_err", 32'(err_cyc), 32'd1);
        chk("t5a_err_pos", 32'(err_pos), 32'd1523);
        chk("t5a_done", 32'(done_cnt), 32'd0);
        run_frames("t5b", 1, 1500, 8'h5A, -1, -1, 2000);
        chk("t5b_len", 32'(flen[0]), 32'd1526);
        chk("t5b_err", 32'(err_cyc), 32'd0);
        chk("t5b_done", 32'(done_cnt), 32'd1);
        cmp_frame("t5b", 0, m, 1500, 8'h5A);

        // Reset in the middle of the payload
        run_frames("t6", 1, 60, 8'h21, -1, 40, 300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_phy_val", 32'(phy_val), 32'd0);
        chk("t6_phy_dat", 32'(phy_dat), 32'd0);
        chk("t6_phy_err", 32'(phy_err), 32'd0);
        chk("t6_req", 32'(mac_req), 32'd0);
        chk("t6_ack", 32'(mac_ack), 32'd0);
        chk("t6_done", 32'(mac_done), 32'd0);
        mac_rdy = 0; mac_strm_val = 0; mac_strm_sof = 0; mac_strm_eof = 0; mac_strm_dat = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frames("t6r", 1, 46, 8'h77, -1, -1, 300);
        chk("t6r_first_val", 32'(first_val), 32'd1);
        chk("t6r_len", 32'(flen[0]), 32'd72);
        chk("t6r_done", 32'(done_cnt), 32'd1);
        cmp_frame("t6r", 0, m, 46, 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
